audio_note_decoder: RTL and testbench

- Receiver-side counterpart of the on-chip square-wave tone generator.
- Samples a 1-bit square-wave audio line and measures its half-period in timebase ticks. The tick length matches the generator's synth clock.
- Locks onto a stable pitch, reports the 7-bit half-period code, and flags note onsets and silence.
- Serves as a self-check and loopback monitor beside the audio engine, and as a decoder for an external tone input.

---
 rtl/audio_note_decoder.sv | 121 ++++++++++++
 tb/tb_audio_note_decoder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/audio_note_decoder.sv
// audio_note_decoder: measures the half-period of a square-wave line in timebase ticks and locks onto stable pitches.
// Defining NOTE_INDEX_EN adds a registered note_idx lookup of the locked half-period.
module audio_note_decoder #(
   parameter int TICK_DIV      = 2048,
   parameter int MIN_HP        = 8,
   parameter int TOL           = 1,
   parameter int LOCK_COUNT    = 3,
   parameter int SILENCE_TICKS = 200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       audio,
   output logic [6:0] hp_out,
   output logic       note_active,
   output logic       note_strobe
`ifdef NOTE_INDEX_EN
   ,
   output logic [3:0] note_idx
`endif
);
   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {SILENT, ACQUIRE, LOCKED} state_t;

   state_t        state, state_n;
   logic          sync1, audio_s, audio_d, edge_hit, tick, valid, silence;
   logic          strobe_n, act_n;
   logic [PW-1:0] pre;
   logic [7:0]    run_ctr, m;
   logic [8:0]    m_sum;
   logic [6:0]    cand, cand_n, hp_n;
   logic [2:0]    cnt, cnt_n;

   function automatic logic near(input logic [7:0] a, input logic [7:0] b);
      return ((a >= b) ? a - b : b - a) <= 8'(TOL);
   endfunction

   assign edge_hit = audio_s ^ audio_d;
   assign tick     = pre == PW'(TICK_DIV - 1);
   // round to the nearest tick using the prescaler phase at the edge
   assign m_sum    = {1'b0, run_ctr} + 9'(pre >= PW'(TICK_DIV / 2));
   assign m        = m_sum[8] ? 8'hFF : m_sum[7:0];
   assign valid    = m >= 8'(MIN_HP) && m <= 8'd127;
   assign silence  = !edge_hit && run_ctr >= 8'(SILENCE_TICKS);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync1       <= 1'b0;
         audio_s     <= 1'b0;
         audio_d     <= 1'b0;
         pre         <= '0;
         run_ctr     <= '0;
         state       <= SILENT;
         cand        <= '0;
         cnt         <= '0;
         hp_out      <= '0;
         note_active <= 1'b0;
         note_strobe <= 1'b0;
      end else begin
         sync1       <= audio;
         audio_s     <= sync1;
         audio_d     <= audio_s;
         pre         <= (edge_hit || tick) ? '0 : pre + 1'b1;
         run_ctr     <= edge_hit ? '0 : (tick && run_ctr != 8'hFF) ? run_ctr + 1'b1 : run_ctr;
         state       <= state_n;
         cand        <= cand_n;
         cnt         <= cnt_n;
         hp_out      <= hp_n;
         note_active <= act_n;
         note_strobe <= strobe_n;
      end

   always_comb begin
      state_n  = state;
      cand_n   = cand;
      cnt_n    = cnt;
      hp_n     = hp_out;
      strobe_n = 1'b0;
      if (silence)
         state_n = SILENT;
      else if (edge_hit)
         case (state)
            SILENT: begin
               state_n = ACQUIRE;
               cnt_n   = '0;
            end
            ACQUIRE: begin
               cnt_n  = !valid ? 3'd0 : near(m, {1'b0, cand}) ? cnt + 1'b1 : 3'd1;
               cand_n = (valid && !near(m, {1'b0, cand})) ? m[6:0] : cand;
               if (cnt_n == 3'(LOCK_COUNT)) begin
                  state_n  = LOCKED;
                  hp_n     = cand_n;
                  strobe_n = 1'b1;
               end
            end
            default:
               if (!(valid && near(m, {1'b0, hp_out}))) begin
                  state_n = ACQUIRE;
                  cnt_n   = valid ? 3'd1 : 3'd0;
                  cand_n  = valid ? m[6:0] : cand;
               end
         endcase
      act_n = state_n == LOCKED;
   end

`ifdef NOTE_INDEX_EN
   localparam logic [6:0] NOTE_TAB [12] = '{7'd100, 7'd84, 7'd74, 7'd70, 7'd62, 7'd55,
                                            7'd47, 7'd42, 7'd37, 7'd35, 7'd31, 7'd28};

   // scanning backwards leaves the earliest table match as the result
   function automatic logic [3:0] lookup(input logic [6:0] hp);
      lookup = 4'hF;
      for (int i = 11; i >= 0; i--)
         if (near({1'b0, hp}, {1'b0, NOTE_TAB[i]})) lookup = 4'(i);
   endfunction

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) note_idx <= 4'hF;
      else        note_idx <= act_n ? lookup(hp_n) : 4'hF;
`endif
endmodule

// File: tb/tb_audio_note_decoder.sv
// tb_audio_note_decoder: directed and randomized half-period stimulus checked against a behavioural note-lock model.
// Define NOTE_INDEX_EN for both files to also check note_idx.
module tb_audio_note_decoder;
   localparam int T = 16;

   logic       clk = 1'b0, rst_n = 1'b1, audio = 1'b0;
   logic [6:0] hp_out;
   logic       note_active, note_strobe;
`ifdef NOTE_INDEX_EN
   logic [3:0] note_idx;
`endif

   int n_pass = 0, n_chk = 0, strobes = 0;
   bit m_silent = 1'b1, m_locked = 1'b0;
   int m_cand = 0, m_cnt = 0, m_hp = 0, m_strobes = 0, prev_base = 47;

   audio_note_decoder #(.TICK_DIV(T)) dut (
      .clk(clk), .rst_n(rst_n), .audio(audio), .hp_out(hp_out),
      .note_active(note_active), .note_strobe(note_strobe)
`ifdef NOTE_INDEX_EN
      , .note_idx(note_idx)
`endif
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (note_strobe) strobes++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int abs_diff(input int a, input int b);
      return a > b ? a - b : b - a;
   endfunction

   function automatic int exp_idx();
      int tab[12] = '{100, 84, 74, 70, 62, 55, 47, 42, 37, 35, 31, 28};
      if (!m_locked) return 15;
      foreach (tab[i]) if (abs_diff(m_hp, tab[i]) <= 1) return i;
      return 15;
   endfunction

   task automatic check(input string tag);
      chk({tag, " hp_out"}, 32'(hp_out), 32'(m_hp));
      chk({tag, " note_active"}, 32'(note_active), 32'(m_locked));
      chk({tag, " strobe_count"}, 32'(strobes), 32'(m_strobes));
`ifdef NOTE_INDEX_EN
      chk({tag, " note_idx"}, 32'(note_idx), 32'(exp_idx()));
`endif
   endtask

   // interval of d clocks between edges rounds to the nearest whole tick
   task automatic model_edge(input int d);
      int m;
      bit v;
      m = (d - 1 + T / 2) / T;
      if (m > 255) m = 255;
      v = m >= 8 && m <= 127;
      if (m_silent) begin
         m_silent = 1'b0;
         m_cnt    = 0;
      end else if (m_locked) begin
         if (!(v && abs_diff(m, m_hp) <= 1)) begin
            m_locked = 1'b0;
            m_cnt    = v ? 1 : 0;
            if (v) m_cand = m;
         end
      end else begin
         if (!v) m_cnt = 0;
         else if (abs_diff(m, m_cand) <= 1) m_cnt++;
         else begin
            m_cand = m;
            m_cnt  = 1;
         end
         if (m_cnt == 3) begin
            m_locked = 1'b1;
            m_hp     = m_cand;
            m_strobes++;
         end
      end
   endtask

   task automatic step(input int d, input string tag);
      repeat (d) @(posedge clk);
      #1;
      if (d > 200 * T + 8) begin
         m_silent = 1'b1;
         m_locked = 1'b0;
      end
      check(tag);
      audio = ~audio;
      model_edge(d);
   endtask

   task automatic model_reset();
      m_silent = 1'b1;
      m_locked = 1'b0;
      m_cand   = 0;
      m_cnt    = 0;
      m_hp     = 0;
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1 check("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 6; k++) step(47 * T, "lock47");
      step(260 * T, "silence");
      for (int k = 0; k < 9; k++) step((k % 3 == 0 ? 47 : k % 3 == 1 ? 48 : 46) * T, "wobble");
      for (int k = 0; k < 4; k++) step(62 * T, "jump62");
      for (int k = 0; k < 20; k++) step(4 * T, "glitch");
      for (int k = 0; k < 4; k++) step(50 * T, "lock50");
      step(10, "pre_reset");
      @(posedge clk);
      #1 rst_n = 1'b0;
      audio = 1'b0;
      model_reset();
      #2 check("async_reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 5; k++) step(47 * T, "relock");
      for (int k = 0; k < 30; k++) begin
         int base;
         base = ($urandom_range(0, 3) != 0) ? prev_base + int'($urandom_range(0, 2)) - 1
                                            : int'($urandom_range(3, 70));
         if (base < 3) base = 3;
         prev_base = base;
         step(base * T + int'($urandom_range(0, T - 1)) - T / 2, "random");
      end
      step(20, "final");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
